// File: rtl/regfile_writer_pkg.sv
// regfile_writer_pkg
//   Shared pipeline types used by the GPR write-port merger.
//   creg_addr_t : 5-bit architectural register index (r0 is hardwired zero)
//   word_t      : 32-bit data word
package regfile_writer_pkg;

    typedef logic [4:0]  creg_addr_t;
    typedef logic [31:0] word_t;

endpackage

// File: rtl/regfile_writer_wb_skid_buf.sv
// wb_skid_buf
//   One-entry skid buffer for long-unit results that arrive while the W stage
//   owns the GPR write port.
//
//   Handshake: a result transfers when in_valid && in_ready in the same cycle.
//   in_ready is high only while the entry is empty and reset is low. A
//   transferred result is held here only if port_busy is high that cycle;
//   otherwise the parent commits it by cut-through and this entry stays empty.
//
//   Ports
//     clk, reset          : clock, synchronous active-high reset
//     in_valid/in_ready   : long-unit offer / acceptance
//     in_dst, in_data     : long-unit destination and result
//     port_busy           : W stage owns the write port this cycle
//     drain_en            : buffered entry commits this cycle
//     full                : entry holds a result
//     out_dst, out_data   : buffered destination and result
module wb_skid_buf
    import regfile_writer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  creg_addr_t in_dst,
    input  word_t      in_data,
    input  logic       port_busy,
    output logic       drain_en,
    output logic       full,
    output creg_addr_t out_dst,
    output word_t      out_data
);

    logic       full_q, full_d;
    creg_addr_t dst_q, dst_d;
    word_t      data_q, data_d;

    always_comb begin
        in_ready = !full_q && !reset;
        drain_en = full_q && !port_busy;
        full_d   = full_q;
        dst_d    = dst_q;
        data_d   = data_q;
        if (drain_en) begin
            full_d = 1'b0;
        end
        // Load only needs the port to be taken; drain and load are exclusive
        // because loading requires the entry to be empty.
        if (in_valid && in_ready && port_busy) begin
            full_d = 1'b1;
            dst_d  = in_dst;
            data_d = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= 1'b0;
            dst_q  <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            dst_q  <= dst_d;
            data_q <= data_d;
        end
    end

    assign full     = full_q;
    assign out_dst  = dst_q;
    assign out_data = data_q;

endmodule

// File: rtl/regfile_writer.sv
// regfile_writer
//   Owns the GPR write port. Merges W-stage results with long-latency results
//   (through a one-entry skid buffer) and keeps a per-register busy scoreboard
//   so decode can stall on RAW/WAW hazards against outstanding long writes.
//
//   Commit priority each cycle: W stage, then skid buffer, then cut-through of
//   the long-unit offer. Writes to r0 are suppressed.
//
//   Optional feature: define REGFILE_WRITER_BYPASS_EN to let a busy source
//   whose write commits this cycle proceed without stalling (requires the GPR
//   file to forward same-cycle write data on reads).
//
//   Ports
//     clk, reset                 : clock, synchronous active-high reset
//     wb_valid/wb_dst/wb_data    : W-stage result (never stalled)
//     iss_valid/iss_dst/iss_long : decode issue; long results return on lu_*
//     lu_valid/lu_dst/lu_data    : long-unit result offer
//     lu_ready                   : long-unit result accepted
//     ra1, ra2                   : decode source registers
//     stall                      : decode must not issue
//     wa3/write_enable/wd3       : GPR write port (wa3/wd3 zero when idle)
//     idle                       : no busy bits and skid buffer empty
module regfile_writer
    import regfile_writer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       wb_valid,
    input  creg_addr_t wb_dst,
    input  word_t      wb_data,
    input  logic       iss_valid,
    input  creg_addr_t iss_dst,
    input  logic       iss_long,
    input  logic       lu_valid,
    input  creg_addr_t lu_dst,
    input  word_t      lu_data,
    output logic       lu_ready,
    input  creg_addr_t ra1,
    input  creg_addr_t ra2,
    output logic       stall,
    output creg_addr_t wa3,
    output logic       write_enable,
    output word_t      wd3,
    output logic       idle
);

    logic [31:1] busy_q, busy_d;
    logic [31:0] busy_vec;    // busy_q with r0 pinned to 0 for direct indexing
    logic [31:0] busy_next;

    logic       buf_full, buf_drain;
    creg_addr_t buf_dst;
    word_t      buf_data;

    logic       commit_valid, commit_long;
    creg_addr_t commit_dst;
    word_t      commit_data;
    logic       issue_set;
    logic       ra1_busy, ra2_busy;

    wb_skid_buf u_skid (
        .clk      (clk),
        .reset    (reset),
        .in_valid (lu_valid),
        .in_ready (lu_ready),
        .in_dst   (lu_dst),
        .in_data  (lu_data),
        .port_busy(wb_valid),
        .drain_en (buf_drain),
        .full     (buf_full),
        .out_dst  (buf_dst),
        .out_data (buf_data)
    );

    assign busy_vec = {busy_q, 1'b0};

    // Commit source select.
    always_comb begin
        commit_valid = 1'b0;
        commit_long  = 1'b0;
        commit_dst   = '0;
        commit_data  = '0;
        if (wb_valid) begin
            commit_valid = 1'b1;
            commit_dst   = wb_dst;
            commit_data  = wb_data;
        end else if (buf_drain) begin
            commit_valid = 1'b1;
            commit_long  = 1'b1;
            commit_dst   = buf_dst;
            commit_data  = buf_data;
        end else if (lu_valid && lu_ready) begin
            commit_valid = 1'b1;
            commit_long  = 1'b1;
            commit_dst   = lu_dst;
            commit_data  = lu_data;
        end
    end

    assign write_enable = commit_valid && (commit_dst != '0) && !reset;
    assign wa3          = write_enable ? commit_dst  : '0;
    assign wd3          = write_enable ? commit_data : '0;

    // Hazard detection.
    always_comb begin
        ra1_busy = busy_vec[ra1];
        ra2_busy = busy_vec[ra2];
`ifdef REGFILE_WRITER_BYPASS_EN
        // The GPR file forwards this cycle's write, so the source is ready.
        if (write_enable && (wa3 == ra1)) ra1_busy = 1'b0;
        if (write_enable && (wa3 == ra2)) ra2_busy = 1'b0;
`endif
        stall = iss_valid && (ra1_busy || ra2_busy || busy_vec[iss_dst]);
    end

    assign issue_set = iss_valid && !stall && iss_long && (iss_dst != '0);

    // Scoreboard update: clear first so that a same-cycle set wins.
    always_comb begin
        busy_next = busy_vec;
        if (commit_long) begin
            busy_next[commit_dst] = 1'b0;
        end
        if (issue_set) begin
            busy_next[iss_dst] = 1'b1;
        end
        busy_d = busy_next[31:1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign idle = !buf_full && (busy_q == '0);

`ifndef SYNTHESIS
    // A long-unit result must target a register the scoreboard marked busy.
    a_lu_dst_busy : assert property (@(posedge clk) disable iff (reset)
        (lu_valid && lu_ready && (lu_dst != '0)) |-> busy_vec[lu_dst]);
`endif

endmodule

// File: tb/tb_regfile_writer.sv
module tb_regfile_writer;
  import regfile_writer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic       wb_valid, iss_valid, iss_long, lu_valid;
  creg_addr_t wb_dst, iss_dst, lu_dst, ra1, ra2, wa3;
  word_t      wb_data, lu_data, wd3;
  logic       lu_ready, stall, write_enable, idle;

  regfile_writer dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
    .iss_valid(iss_valid), .iss_dst(iss_dst), .iss_long(iss_long),
    .lu_valid(lu_valid), .lu_dst(lu_dst), .lu_data(lu_data), .lu_ready(lu_ready),
    .ra1(ra1), .ra2(ra2), .stall(stall),
    .wa3(wa3), .write_enable(write_enable), .wd3(wd3), .idle(idle)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Architectural view: a set of registers awaiting a long result, an optional
  // parked long result, and the long unit's list of results still to return.
  typedef struct {
    logic [4:0]  dst;
    logic [31:0] data;
  } lu_item_t;

  bit         m_busy[32];
  bit         m_buf_full;
  lu_item_t   m_buf;
  lu_item_t   lu_q[$];
  lu_item_t   lu_cur;
  bit         lu_offering;
  bit         auto_lu;

  int          c_src;       // 0 none, 1 W stage, 2 parked, 3 cut-through
  logic [4:0]  c_dst;
  logic [31:0] c_data;
  logic        e_lu_ready, e_we, e_stall, e_idle;
  logic [4:0]  e_wa3;
  logic [31:0] e_wd3;

  task automatic model_clear();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_buf_full  = 1'b0;
    lu_q.delete();
    lu_offering = 1'b0;
  endtask

  task automatic compute_expected();
    bit s1, s2;
    int nb;
    e_lu_ready = !m_buf_full && !reset;
    c_src = 0; c_dst = '0; c_data = '0;
    if (wb_valid) begin
      c_src = 1; c_dst = wb_dst; c_data = wb_data;
    end else if (m_buf_full) begin
      c_src = 2; c_dst = m_buf.dst; c_data = m_buf.data;
    end else if (lu_valid && e_lu_ready) begin
      c_src = 3; c_dst = lu_dst; c_data = lu_data;
    end
    e_we  = (c_src != 0) && (c_dst != 0) && !reset;
    e_wa3 = e_we ? c_dst : 5'd0;
    e_wd3 = e_we ? c_data : 32'd0;
    s1 = m_busy[ra1];
    s2 = m_busy[ra2];
`ifdef REGFILE_WRITER_BYPASS_EN
    if (e_we && e_wa3 == ra1) s1 = 1'b0;
    if (e_we && e_wa3 == ra2) s2 = 1'b0;
`endif
    e_stall = iss_valid && (s1 || s2 || m_busy[iss_dst]);
    nb = 0;
    foreach (m_busy[i]) if (m_busy[i]) nb++;
    e_idle = !m_buf_full && (nb == 0);
  endtask

  task automatic update_model();
    bit accepted;
    accepted = lu_valid && e_lu_ready;
    if (reset) begin
      model_clear();
    end else begin
      if (c_src == 2 || c_src == 3) m_busy[c_dst] = 1'b0;
      if (c_src == 2) m_buf_full = 1'b0;
      if (accepted && wb_valid) begin
        m_buf_full = 1'b1;
        m_buf.dst  = lu_dst;
        m_buf.data = lu_data;
      end
      if (accepted) lu_offering = 1'b0;
      if (iss_valid && !e_stall && iss_long) begin
        if (iss_dst != 0) m_busy[iss_dst] = 1'b1;
        if (auto_lu) lu_q.push_back('{dst: iss_dst, data: $urandom});
      end
      m_busy[0] = 1'b0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    wb_valid = 0; wb_dst = 0; wb_data = 0;
    iss_valid = 0; iss_dst = 0; iss_long = 0;
    lu_valid = 0; lu_dst = 0; lu_data = 0;
    ra1 = 0; ra2 = 0;
  endtask

  // Inputs are applied 1 time unit after posedge; outputs are sampled 2 later.
  task automatic settle();
    #2;
    compute_expected();
    chk("write_enable", write_enable, e_we);
    chk("wa3", wa3, e_wa3);
    chk("wd3", wd3, e_wd3);
    chk("lu_ready", lu_ready, e_lu_ready);
    chk("stall", stall, e_stall);
    chk("idle", idle, e_idle);
  endtask

  task automatic advance();
    update_model();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic issue_long(input logic [4:0] d);
    clear_inputs();
    iss_valid = 1; iss_long = 1; iss_dst = d;
    step();
    clear_inputs();
  endtask

  task automatic drive_random_lu();
    if (!lu_offering && lu_q.size() > 0 && $urandom_range(0, 2) != 0) begin
      lu_cur = lu_q.pop_front();
      lu_offering = 1'b1;
    end
    lu_valid = lu_offering;
    lu_dst   = lu_offering ? lu_cur.dst : 5'($urandom_range(0, 31));
    lu_data  = lu_offering ? lu_cur.data : $urandom;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] d;
    int guard;
    auto_lu = 1'b0;
    model_clear();
    clear_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Reset held: port silent, long unit refused.
    settle();
    chk("rst_we", write_enable, 1'b0);
    chk("rst_lu_ready", lu_ready, 1'b0);
    advance();
    reset = 1'b0;
    settle();
    chk("post_rst_idle", idle, 1'b1);
    advance();

    // Cut-through of a long result with the port free.
    issue_long(5'd5);
    lu_valid = 1; lu_dst = 5'd5; lu_data = 32'hDEAD_BEEF;
    settle();
    chk("ct_we", write_enable, 1'b1);
    chk("ct_wa3", wa3, 32'd5);
    chk("ct_wd3", wd3, 32'hDEAD_BEEF);
    chk("ct_ready", lu_ready, 1'b1);
    advance();
    clear_inputs();

    // RAW stall on r8 until its long result commits.
    issue_long(5'd8);
    iss_valid = 1; ra1 = 5'd8;
    settle(); chk("raw_stall_0", stall, 1'b1); advance();
    settle(); chk("raw_stall_1", stall, 1'b1); advance();
    lu_valid = 1; lu_dst = 5'd8; lu_data = 32'h0000_0808;
    settle();
`ifdef REGFILE_WRITER_BYPASS_EN
    chk("raw_commit_stall", stall, 1'b0);
`else
    chk("raw_commit_stall", stall, 1'b1);
`endif
    advance();
    lu_valid = 0;
    settle(); chk("raw_after_stall", stall, 1'b0); advance();
    clear_inputs();

    // Port collision: W stage wins, long result parked then drained.
    issue_long(5'd4);
    wb_valid = 1; wb_dst = 5'd3; wb_data = 32'd1;
    lu_valid = 1; lu_dst = 5'd4; lu_data = 32'd2;
    settle();
    chk("col_wa3", wa3, 32'd3);
    chk("col_wd3", wd3, 32'd1);
    chk("col_ready", lu_ready, 1'b1);
    advance();
    clear_inputs();
    settle();
    chk("drain_we", write_enable, 1'b1);
    chk("drain_wa3", wa3, 32'd4);
    chk("drain_wd3", wd3, 32'd2);
    chk("drain_ready", lu_ready, 1'b0);
    advance();
    settle(); chk("drain_idle", idle, 1'b1); advance();

    // Back-to-back long results while W stage holds the port for 3 cycles.
    issue_long(5'd10);
    issue_long(5'd11);
    wb_valid = 1; wb_dst = 5'd2; wb_data = 32'h2222;
    lu_valid = 1; lu_dst = 5'd10; lu_data = 32'hA0A0;
    settle(); chk("b2b_first_ready", lu_ready, 1'b1); chk("b2b_wb_wa3", wa3, 32'd2); advance();
    lu_dst = 5'd11; lu_data = 32'hB1B1;
    settle(); chk("b2b_second_held0", lu_ready, 1'b0); advance();
    settle(); chk("b2b_second_held1", lu_ready, 1'b0); advance();
    wb_valid = 0;
    settle(); chk("b2b_drain_wa3", wa3, 32'd10); chk("b2b_drain_ready", lu_ready, 1'b0); advance();
    settle(); chk("b2b_ct_wa3", wa3, 32'd11); chk("b2b_ct_wd3", wd3, 32'hB1B1); advance();
    clear_inputs();
    settle(); chk("b2b_idle", idle, 1'b1); advance();

    // Register 0 from every source.
    wb_valid = 1; wb_dst = 5'd0; wb_data = 32'h1234;
    settle(); chk("r0_wb_we", write_enable, 1'b0); chk("r0_wb_wd3", wd3, 32'd0); advance();
    issue_long(5'd0);
    settle(); chk("r0_issue_idle", idle, 1'b1); advance();
    lu_valid = 1; lu_dst = 5'd0; lu_data = 32'h5555;
    settle(); chk("r0_ct_we", write_enable, 1'b0); advance();
    wb_valid = 1; wb_dst = 5'd1; wb_data = 32'h7777;
    settle(); chk("r0_park_wa3", wa3, 32'd1); advance();
    clear_inputs();
    settle(); chk("r0_buf_we", write_enable, 1'b0); chk("r0_buf_ready", lu_ready, 1'b0); advance();
    settle(); chk("r0_final_idle", idle, 1'b1); advance();

    // Reset while a result is parked and r9 is busy.
    issue_long(5'd9);
    issue_long(5'd12);
    wb_valid = 1; wb_dst = 5'd1; wb_data = 32'h1;
    lu_valid = 1; lu_dst = 5'd12; lu_data = 32'hC0C0;
    step();
    clear_inputs();
    settle(); chk("pre_rst_idle", idle, 1'b0); advance();
    reset = 1'b1;
    settle(); chk("mid_rst_we", write_enable, 1'b0); chk("mid_rst_ready", lu_ready, 1'b0); advance();
    reset = 1'b0;
    settle();
    chk("rst_drop_idle", idle, 1'b1);
    chk("rst_drop_ready", lu_ready, 1'b1);
    chk("rst_drop_we", write_enable, 1'b0);
    advance();

    // Randomized traffic; the bench plays the long unit.
    auto_lu = 1'b1;
    for (int n = 0; n < 600; n++) begin
      wb_valid  = ($urandom_range(0, 99) < 40);
      wb_dst    = 5'($urandom_range(0, 31));
      d = $urandom;
      wb_data   = d;
      iss_valid = $urandom_range(0, 1) == 1;
      iss_long  = $urandom_range(0, 1) == 1;
      iss_dst   = 5'($urandom_range(0, 12));
      ra1       = 5'($urandom_range(0, 12));
      ra2       = 5'($urandom_range(0, 12));
      drive_random_lu();
      step();
    end

    // Drain all outstanding long results.
    wb_valid = 0; iss_valid = 0; iss_long = 0;
    guard = 0;
    while ((lu_q.size() > 0 || lu_offering || m_buf_full) && guard < 300) begin
      drive_random_lu();
      step();
      guard++;
    end
    chk("drain_timeout", (guard < 300) ? 1 : 0, 1);
    clear_inputs();
    settle();
    chk("final_idle", idle, 1'b1);
    advance();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
